viterbi_frame_ctrl: RTL and testbench

//  Frame sequencer between the input pads and the PipeViterbi decoder core.
//  The core has no valid or stall and consumes one 16-bit symbol word every clock.

---
 rtl/viterbi_frame_ctrl_if.sv | 62 ++++++
 rtl/viterbi_frame_ctrl.sv | 173 +++++++++++++++++
 tb/tb_viterbi_frame_ctrl.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/viterbi_frame_ctrl_if.sv
// ---------------------------------------------------------------------------
// viterbi_frame_ctrl_if
//   Bundle of the frame-control, pad-symbol, decoder and result signals of
//   viterbi_frame_ctrl. clk/rst stay outside the bundle as plain ports.
//
//   master : the environment side (drives start/frame_len/sym_*/dec_in)
//   slave  : the frame controller side
//
//   Signals
//     start      1-cycle frame start request
//     frame_len  info symbol count, sampled when start is honoured
//     sym_in     pad symbol word
//     sym_valid  sym_in holds a symbol this cycle
//     sym_ready  controller accepts a symbol this cycle (LOAD only)
//     dec_sym    symbol word presented to the decoder core
//     dec_in     decoded word coming back from the decoder core
//     out_data   decoded info byte (0 when out_valid=0)
//     out_valid  out_data is a decoded info byte
//     busy       frame in progress
//     done       1-cycle pulse, frame fully drained
//     err        sticky protocol error
//     frame_cnt  completed frame count    (only with VCTRL_FRAME_CNT_EN)
//     err_cause  {start-while-busy, underrun} sticky causes (same macro)
// ---------------------------------------------------------------------------
interface viterbi_frame_ctrl_if #(
    parameter int SYM_W = 16,
    parameter int OUT_W = 8,
    parameter int LEN_W = 16
);
    logic             start;
    logic [LEN_W-1:0] frame_len;
    logic [SYM_W-1:0] sym_in;
    logic             sym_valid;
    logic             sym_ready;
    logic [SYM_W-1:0] dec_sym;
    logic [OUT_W-1:0] dec_in;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             busy;
    logic             done;
    logic             err;
`ifdef VCTRL_FRAME_CNT_EN
    logic [15:0]      frame_cnt;
    logic [1:0]       err_cause;
`endif

    modport master (
        output start, frame_len, sym_in, sym_valid, dec_in,
        input  sym_ready, dec_sym, out_data, out_valid, busy, done, err
`ifdef VCTRL_FRAME_CNT_EN
        , input frame_cnt, err_cause
`endif
    );

    modport slave (
        input  start, frame_len, sym_in, sym_valid, dec_in,
        output sym_ready, dec_sym, out_data, out_valid, busy, done, err
`ifdef VCTRL_FRAME_CNT_EN
        , output frame_cnt, err_cause
`endif
    );
endinterface

// File: rtl/viterbi_frame_ctrl.sv
// ---------------------------------------------------------------------------
// viterbi_frame_ctrl
//   Frame sequencer in front of a stall-free Viterbi decoder core. Each frame
//   feeds frame_len pad symbols (erasures on underrun) to the core, appends
//   TAIL_LEN zero symbols to flush the trellis, then waits for the core
//   pipeline to empty. A tag travels beside every issued word through a delay
//   line matched to the core latency so out_valid flags exactly the decoded
//   info bytes.
//
//   Ports
//     clk   in  single clock
//     rst   in  synchronous active-high reset
//     bus   viterbi_frame_ctrl_if.slave (start, frame_len, sym_in, sym_valid,
//           sym_ready, dec_sym, dec_in, out_data, out_valid, busy, done, err)
//
//   Optional build macro VCTRL_FRAME_CNT_EN adds bus.frame_cnt (completed
//   frames, wraps) and bus.err_cause (bit0 underrun, bit1 start-while-busy).
// ---------------------------------------------------------------------------
module viterbi_frame_ctrl #(
    parameter int SYM_W       = 16,
    parameter int OUT_W       = 8,
    parameter int LEN_W       = 16,
    parameter int TAIL_LEN    = 6,
    parameter int DEC_LATENCY = 32
) (
    input logic                clk,
    input logic                rst,
    viterbi_frame_ctrl_if.slave bus
);
    // Phase counter covers both the TAIL and the DRAIN countdowns.
    localparam int PH_W = $clog2(TAIL_LEN + DEC_LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        TAIL  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t             state_q;
    logic [LEN_W-1:0]   cnt_q;
    logic [PH_W-1:0]    ph_q;
    logic [SYM_W-1:0]   dec_sym_q;
    logic [DEC_LATENCY:0] tag_q;
    logic [OUT_W-1:0]   out_data_q;
    logic               out_valid_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;
    logic               sym_ready_q;

    logic               tag_in;
    logic               tag_out;
    logic               start_busy;
    logic               underrun;
    logic               last_drain;

    // Only words issued in LOAD carry information; tail and drain words do not.
    assign tag_in     = (state_q == LOAD);
    assign tag_out    = tag_q[DEC_LATENCY];
    assign start_busy = bus.start && (state_q != IDLE);
    assign underrun   = (state_q == LOAD) && !bus.sym_valid;
    assign last_drain = (state_q == DRAIN) && (ph_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ph_q        <= '0;
            dec_sym_q   <= '0;
            tag_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            sym_ready_q <= 1'b0;
        end else begin
            // Tag line advances in lock-step with dec_sym; its output lines
            // up with the decoder result for the same word.
            tag_q       <= {tag_q[DEC_LATENCY-1:0], tag_in};
            out_valid_q <= tag_out;
            out_data_q  <= tag_out ? bus.dec_in : '0;
            done_q      <= 1'b0;
            dec_sym_q   <= '0;

            if (start_busy || underrun) begin
                err_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        busy_q <= 1'b1;
                        if (bus.frame_len != '0) begin
                            state_q     <= LOAD;
                            cnt_q       <= bus.frame_len;
                            sym_ready_q <= 1'b1;
                        end else begin
                            state_q <= TAIL;
                            ph_q    <= PH_W'(TAIL_LEN - 1);
                        end
                    end
                end
                LOAD: begin
                    // An underrun still occupies a slot as an erasure so the
                    // core sees a contiguous frame.
                    dec_sym_q <= bus.sym_valid ? bus.sym_in : '0;
                    cnt_q     <= cnt_q - 1'b1;
                    // Leaving on cnt==1 means cnt never reaches 0 in LOAD, so
                    // the largest frame_len cannot wrap the counter.
                    if (cnt_q == LEN_W'(1)) begin
                        state_q     <= TAIL;
                        sym_ready_q <= 1'b0;
                        ph_q        <= PH_W'(TAIL_LEN - 1);
                    end
                end
                TAIL: begin
                    if (ph_q == '0) begin
                        state_q <= DRAIN;
                        ph_q    <= PH_W'(DEC_LATENCY);
                    end else begin
                        ph_q <= ph_q - 1'b1;
                    end
                end
                DRAIN: begin
                    if (ph_q == '0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        ph_q <= ph_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.sym_ready = sym_ready_q;
    assign bus.dec_sym   = dec_sym_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

`ifdef VCTRL_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;
    logic [1:0]  err_cause_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
            err_cause_q <= '0;
        end else begin
            // Counts in the same edge that raises done.
            if (last_drain) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            if (underrun) begin
                err_cause_q[0] <= 1'b1;
            end
            if (start_busy) begin
                err_cause_q[1] <= 1'b1;
            end
        end
    end

    assign bus.frame_cnt = frame_cnt_q;
    assign bus.err_cause = err_cause_q;
`endif
endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
`timescale 1ns/1ps
module tb_viterbi_frame_ctrl;
    localparam int SYM_W       = 16;
    localparam int OUT_W       = 8;
    localparam int LEN_W       = 8;
    localparam int TAIL_LEN    = 6;
    localparam int DEC_LATENCY = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    viterbi_frame_ctrl_if #(.SYM_W(SYM_W), .OUT_W(OUT_W), .LEN_W(LEN_W)) bus ();

    viterbi_frame_ctrl #(
        .SYM_W(SYM_W), .OUT_W(OUT_W), .LEN_W(LEN_W),
        .TAIL_LEN(TAIL_LEN), .DEC_LATENCY(DEC_LATENCY)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ov_count = 0;
    int done_count = 0;
    int first_ov_cyc = -1;
    logic [OUT_W-1:0] exp_q[$];
    bit   exp_err = 1'b0;
    bit [1:0] exp_cause = 2'b00;
    int   exp_frames = 0;

    // Stand-in for the decoder core: a fixed byte mapping seen DEC_LATENCY
    // cycles after the symbol is presented. f(0) is non-zero so ungated
    // tail results would be visible on out_data.
    function automatic logic [OUT_W-1:0] dmap(input logic [SYM_W-1:0] s);
        return s[15:8] ^ s[7:0] ^ 8'h5A;
    endfunction

    logic [SYM_W-1:0] pipe [DEC_LATENCY];
    always @(posedge clk) begin
        pipe[0] <= bus.dec_sym;
        for (int k = 1; k < DEC_LATENCY; k++) pipe[k] <= pipe[k-1];
    end
    assign bus.dec_in = dmap(pipe[DEC_LATENCY-1]);

    function automatic void chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor / scoreboard: pops one expected byte per out_valid.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (bus.out_valid) begin
                ov_count++;
                if (first_ov_cyc < 0) first_ov_cyc = cyc;
                if (exp_q.size() == 0) chk("out_valid_unexpected", bus.out_valid, 0);
                else                   chk("out_data", bus.out_data, exp_q.pop_front());
            end else if (bus.out_data != '0) begin
                chk("out_data_idle_zero", bus.out_data, 0);
            end
            if (bus.done) done_count++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        exp_q.delete();
        exp_err    = 1'b0;
        exp_cause  = 2'b00;
        exp_frames = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.sym_valid = 1'b0;
        tick();
        tick();
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_dec_sym", bus.dec_sym, 0);
        chk("rst_sym_ready", bus.sym_ready, 0);
`ifdef VCTRL_FRAME_CNT_EN
        chk("rst_frame_cnt", bus.frame_cnt, 0);
        chk("rst_err_cause", bus.err_cause, 0);
`endif
        rst = 1'b0;
        clear_model();
    endtask

    task automatic start_frame(input int n);
        bus.frame_len = LEN_W'(n);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.frame_len = LEN_W'($urandom);   // must not affect the running frame
    endtask

    task automatic load_frame(input int n, input int pct_bad, input int bad_slot, output int acc_cyc);
        logic [SYM_W-1:0] s;
        bit v;
        acc_cyc = cyc;
        for (int i = 0; i < n; i++) begin
            s = SYM_W'($urandom);
            v = (int'($urandom_range(99)) >= pct_bad) && (i != bad_slot);
            bus.sym_in = s;
            bus.sym_valid = v;
            chk("sym_ready_load", bus.sym_ready, 1);
            exp_q.push_back(dmap(v ? s : '0));
            if (!v) begin
                exp_err = 1'b1;
                exp_cause[0] = 1'b1;
            end
            tick();
            chk("dec_sym", bus.dec_sym, v ? s : '0);
        end
        bus.sym_valid = 1'b0;
        bus.sym_in = SYM_W'($urandom);
    endtask

    task automatic wait_done(input int budget, output bit ready_seen, output bit sym_nonzero);
        bit got;
        got = 1'b0;
        ready_seen = 1'b0;
        sym_nonzero = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (bus.done) begin
                got = 1'b1;
                break;
            end
            if (bus.sym_ready) ready_seen = 1'b1;
            if (bus.dec_sym != '0) sym_nonzero = 1'b1;
        end
        if (!got) chk("done_timeout", bus.done, 1);
        else      exp_frames++;
    endtask

    // One full frame from an idle controller, optionally poking start in TAIL.
    task automatic run_frame(input int n, input int pct_bad, input int bad_slot, input bit poke);
        int c0, acc, ov0, d0;
        bit rs, nz;
        ov0 = ov_count;
        d0 = done_count;
        first_ov_cyc = -1;
        c0 = cyc;
        start_frame(n);
        chk("busy_after_start", bus.busy, 1);
        load_frame(n, pct_bad, bad_slot, acc);
        if (poke) begin
            bus.start = 1'b1;
            bus.frame_len = LEN_W'($urandom_range(1, 9));
            tick();
            bus.start = 1'b0;
            exp_err = 1'b1;
            exp_cause[1] = 1'b1;
            chk("err_after_poke", bus.err, 1);
        end
        wait_done(200 + n, rs, nz);
        chk("done_time", cyc - c0, n + TAIL_LEN + DEC_LATENCY + 2);
        chk("busy_at_done", bus.busy, 0);
        chk("tail_drain_dec_sym_zero", nz, 0);
        chk("sym_ready_outside_load", rs, 0);
        tick();
        chk("out_valid_count", ov_count - ov0, n);
        chk("done_count", done_count - d0, 1);
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("busy_after_done", bus.busy, 0);
        chk("err", bus.err, exp_err);
        if (n > 0) chk("first_out_latency", first_ov_cyc - acc, DEC_LATENCY + 2);
`ifdef VCTRL_FRAME_CNT_EN
        chk("frame_cnt", bus.frame_cnt, exp_frames);
        chk("err_cause", bus.err_cause, exp_cause);
`endif
    endtask

    initial begin
        int c0, c1, ov0, d0, acc;
        bit rs, nz;
        bus.start = 1'b0;
        bus.frame_len = '0;
        bus.sym_in = '0;
        bus.sym_valid = 1'b0;
        for (int k = 0; k < DEC_LATENCY; k++) pipe[k] = '0;

        do_reset();

        // Basic frame, empty frame, underrun frame, start poked in TAIL.
        run_frame(4, 0, -1, 1'b0);
        run_frame(0, 0, -1, 1'b0);
        run_frame(8, 0, 2, 1'b0);
        run_frame(5, 0, -1, 1'b1);
        chk("err_sticky", bus.err, 1);

        // Back-to-back frames, second start in the done cycle.
        do_reset();
        ov0 = ov_count;
        d0 = done_count;
        c0 = cyc;
        start_frame(3);
        load_frame(3, 0, -1, acc);
        wait_done(250, rs, nz);
        chk("b2b_done1_time", cyc - c0, 3 + TAIL_LEN + DEC_LATENCY + 2);
        c1 = cyc;
        start_frame(5);
        chk("b2b_busy2", bus.busy, 1);
        load_frame(5, 0, -1, acc);
        wait_done(250, rs, nz);
        chk("b2b_done2_time", cyc - c1, 5 + TAIL_LEN + DEC_LATENCY + 2);
        chk("b2b_tail_zero", nz, 0);
        tick();
        chk("b2b_out_valid_total", ov_count - ov0, 8);
        chk("b2b_done_total", done_count - d0, 2);
        chk("b2b_scoreboard_empty", exp_q.size(), 0);
        chk("b2b_err", bus.err, 0);
`ifdef VCTRL_FRAME_CNT_EN
        chk("b2b_frame_cnt", bus.frame_cnt, 2);
`endif

        // Reset in the middle of LOAD abandons the frame.
        start_frame(16);
        load_frame(5, 0, -1, acc);
        rst = 1'b1;
        tick();
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_dec_sym", bus.dec_sym, 0);
        rst = 1'b0;
        clear_model();
        ov0 = ov_count;
        d0 = done_count;
        repeat (40) tick();
        chk("midrst_no_out_valid", ov_count - ov0, 0);
        chk("midrst_no_done", done_count - d0, 0);

        // start coinciding with rst is dropped.
        rst = 1'b1;
        bus.start = 1'b1;
        bus.frame_len = LEN_W'(7);
        tick();
        bus.start = 1'b0;
        rst = 1'b0;
        tick();
        chk("start_with_rst_ignored", bus.busy, 0);
        clear_model();

        // Random frames with occasional underruns, then the longest frame.
        repeat (6) run_frame(int'($urandom_range(1, 24)), 15, -1, 1'b0);
        run_frame((1 << LEN_W) - 1, 0, -1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
